ibex_fpu_wb_stage: RTL and testbench
====================================

# ibex_fpu_wb_stage

Writeback stage directly downstream of the single-cycle FPU datapath. It accepts one FPU result per cycle into a small in-order buffer and retires each entry to the FP register file or to the shared integer write port. The integer port is stalled while the core's own integer writeback holds it. Each entry's exception flags are accumulated into the sticky `fflags` field of `fcsr`. The stage also exports a pending-destination mask for FP hazard detection.

## Interface
- `DEPTH`, 2: buffer entries; legal values 2, 4.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `in_valid_i`  in  1  FPU result valid.
- `in_ready_o`  out  1  stage can accept this cycle.
- `in_dest_i`  in  1  `fpu_dest_e` value: FP or INT register file.
- `in_rd_addr_i`  in  5  destination register.
- `in_wdata_i`  in  32  result data.
- `in_status_i`  in  8  FPU status; bits[4:0] = {NV,DZ,OF,UF,NX}; bits[7:5] ignored.
- `int_wb_busy_i`  in  1  core owns the integer write port this cycle.
- `flush_i`  in  1  discard all buffered entries.
- `csr_fflags_we_i`  in  1  CSR write to `fflags`.
- `csr_fflags_wdata_i`  in  5  CSR write value.
- `fp_regfile_wdata_o` / `fp_regfile_addr_o` / `fp_regfile_write_o`  out  32/5/1  FP register file write.
- `int_regfile_wdata_o` / `int_regfile_addr_o` / `int_regfile_write_o`  out  32/5/1  integer register file write.
- `fflags_o`  out  5  sticky accrued exception flags.
- `fp_pending_o`  out  32  bit r set while any buffered entry targets FP register r.

## Operation
- Enqueue when `in_valid_i && in_ready_o`. `in_ready_o = !full`. There is no bypass: when full, a same-cycle dequeue does not raise ready.
- Head entry retires in order:
  - FP dest: retires every cycle it is at the head.
  - INT dest: retires only when `!int_wb_busy_i`. While busy, the head blocks every entry behind it.
- On retire, the matching write strobe is high for exactly one cycle, with address and data taken from the entry.
- INT dest with `rd=0`: the entry retires and its flags accrue, but `int_regfile_write_o` stays 0.
- FP dest with `rd=0`: written normally; f0 is a real register.
- Flag update each cycle, with R = retiring entry's status[4:0] (0 if nothing retires):
  - `fflags_next = (csr_fflags_we_i ? csr_fflags_wdata_i : fflags_q) | R`.
  - The CSR write never loses flags from a same-cycle retire.
- `fp_pending_o` is the combinational OR of the one-hot decode of every valid FP-dest entry.
- `flush_i`:
  - Empties the buffer at the next edge, and any same-cycle enqueue is dropped.
  - The head may still retire in the flush cycle; its write and its flags are honoured.
  - Already-accrued flags are unaffected.
- Outputs not driving a write (`*_wdata_o`, `*_addr_o`) are 0 when the strobe is 0.

## Timing
- Entry enqueued at edge N is visible at the head at edge N; its write strobe asserts in cycle N+1 at the earliest (one-cycle latency). Its bit in `fp_pending_o` sets in cycle N+1 and clears in the cycle after retire.
- Throughput: one entry per cycle in steady state with no INT stalls.
- Full buffer with head retiring: `in_ready_o` stays 0 that cycle and rises the following cycle.
- Reset applies at the clock edge while `rst_i` is high. After that edge: buffer empty, `in_ready_o=1`, all write strobes 0, `fflags_o=0`, `fp_pending_o=0`. Inputs are ignored while `rst_i` is high.
- Reset mid-operation discards buffered entries without writing them.
- Read/write pointers wrap modulo `DEPTH`. Occupancy uses a `$clog2(DEPTH)+1`-bit counter.

## Structure
- `ibex_pkg` additions:
  - `fpu_dest_e` {FPU_DEST_FP, FPU_DEST_INT}.
  - `fpu_wb_entry_t` struct {dest, rd_addr[4:0], wdata[31:0], fflags[4:0]}.
  - Localparams `FFLAG_NV=4 … FFLAG_NX=0`.
- One sub-module, `ibex_fpu_wb_fifo`: a parameterized FIFO of `fpu_wb_entry_t` with flush and per-entry valid visibility, used for the pending mask.
- Retire gating, flag accumulation and output muxing live in the top module.

## Test plan
- Back-to-back: four FP results to f1..f4, data 0x3F800000+i, status 0. Expect writes in cycles 1..4 with matching addr/data, `in_ready_o` never low, `fp_pending_o` bit i high for exactly one cycle each.
- INT stall: INT entry to x5 (data 0xDEADBEEF), then FP to f2, with `int_wb_busy_i` high 3 cycles. Expect no writes during the stall, then x5 write, then f2 write the next cycle. With DEPTH=2, `in_ready_o` is 0 while full.
- Flags: retire entries with status 0x10, then 0x01. Expect `fflags_o`=0x10, then 0x11. Then a CSR write of 0x00 in the same cycle as a retire with 0x04: expect `fflags_o`=0x04.
- x0 drop: INT entry, rd=0, status 0x02. Expect `int_regfile_write_o` stays 0 and `fflags_o` bit UF sets.
- Flush: fill DEPTH entries (FP dests), assert `flush_i`. Expect only the head to write, `fp_pending_o`=0 next cycle, and `in_ready_o`=1.
- Reset mid-run: `rst_i` pulse with 2 buffered entries and `fflags_o`=0x1F. Expect no further writes, `fflags_o`=0 and `fp_pending_o`=0 after the edge.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the FPU writeback stage.
package ibex_pkg;

  typedef enum logic {
    FPU_DEST_FP  = 1'b0,
    FPU_DEST_INT = 1'b1
  } fpu_dest_e;

  typedef struct packed {
    fpu_dest_e   dest;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [4:0]  fflags;
  } fpu_wb_entry_t;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

endpackage

// File: rtl/ibex_fpu_wb_fifo.sv
// In-order buffer of FPU results with flush and per-slot valid bits.
module ibex_fpu_wb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fpu_wb_entry_t din,
  output fpu_wb_entry_t head,
  output logic          empty,
  output logic          full,
  output logic [DEPTH-1:0] slot_valid,
  output fpu_wb_entry_t slots [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fpu_wb_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign slots = mem;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off = PTR_W'(i) - rd_ptr;
      slot_valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/ibex_fpu_wb_stage.sv
// FPU writeback: buffers results, retires to FP/INT regfiles, accrues fflags.
module ibex_fpu_wb_stage
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_dest_i,
  input  logic [4:0]  in_rd_addr_i,
  input  logic [31:0] in_wdata_i,
  input  logic [7:0]  in_status_i,
  input  logic        int_wb_busy_i,
  input  logic        flush_i,
  input  logic        csr_fflags_we_i,
  input  logic [4:0]  csr_fflags_wdata_i,
  output logic [31:0] fp_regfile_wdata_o,
  output logic [4:0]  fp_regfile_addr_o,
  output logic        fp_regfile_write_o,
  output logic [31:0] int_regfile_wdata_o,
  output logic [4:0]  int_regfile_addr_o,
  output logic        int_regfile_write_o,
  output logic [4:0]  fflags_o,
  output logic [31:0] fp_pending_o
);

  fpu_wb_entry_t    in_entry;
  fpu_wb_entry_t    head;
  fpu_wb_entry_t    slots [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic             empty;
  logic             full;
  logic             push;
  logic             retire;
  logic             head_fp;
  logic [4:0]       ret_flags;
  logic [4:0]       fflags_q;
  logic             unused_status;

  assign unused_status = ^in_status_i[7:5];

  assign in_entry = '{
    dest:    fpu_dest_e'(in_dest_i),
    rd_addr: in_rd_addr_i,
    wdata:   in_wdata_i,
    fflags:  in_status_i[4:0]
  };

  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;

  ibex_fpu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush_i),
    .push       (push),
    .pop        (retire),
    .din        (in_entry),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .slot_valid (slot_valid),
    .slots      (slots)
  );

  // An INT head waits for the shared port and blocks everything behind it.
  assign head_fp = (head.dest == FPU_DEST_FP);
  assign retire  = !rst_i && !empty && (head_fp || !int_wb_busy_i);

  assign fp_regfile_write_o  = retire && head_fp;
  assign int_regfile_write_o = retire && !head_fp && (head.rd_addr != 5'd0);

  assign fp_regfile_addr_o   = fp_regfile_write_o ? head.rd_addr : '0;
  assign fp_regfile_wdata_o  = fp_regfile_write_o ? head.wdata : '0;
  assign int_regfile_addr_o  = int_regfile_write_o ? head.rd_addr : '0;
  assign int_regfile_wdata_o = int_regfile_write_o ? head.wdata : '0;

  assign ret_flags = retire ? head.fflags : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= (csr_fflags_we_i ? csr_fflags_wdata_i : fflags_q) | ret_flags;
    end
  end

  assign fflags_o = fflags_q;

  always_comb begin
    fp_pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && slots[i].dest == FPU_DEST_FP) begin
        fp_pending_o[slots[i].rd_addr] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_fpu_wb_stage.sv
// Directed bench for ibex_fpu_wb_stage with immediate assertions.
module tb_ibex_fpu_wb_stage;
  import ibex_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_dest;
  logic [4:0]  in_rd;
  logic [31:0] in_wdata;
  logic [7:0]  in_status;
  logic        busy;
  logic        flush;
  logic        csr_we;
  logic [4:0]  csr_wdata;
  logic [31:0] fp_wdata;
  logic [4:0]  fp_addr;
  logic        fp_write;
  logic [31:0] int_wdata;
  logic [4:0]  int_addr;
  logic        int_write;
  logic [4:0]  fflags;
  logic [31:0] pending;

  int n_asrt = 0;
  int n_fail = 0;

  ibex_fpu_wb_stage #(.DEPTH(2)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_dest_i           (in_dest),
    .in_rd_addr_i        (in_rd),
    .in_wdata_i          (in_wdata),
    .in_status_i         (in_status),
    .int_wb_busy_i       (busy),
    .flush_i             (flush),
    .csr_fflags_we_i     (csr_we),
    .csr_fflags_wdata_i  (csr_wdata),
    .fp_regfile_wdata_o  (fp_wdata),
    .fp_regfile_addr_o   (fp_addr),
    .fp_regfile_write_o  (fp_write),
    .int_regfile_wdata_o (int_wdata),
    .int_regfile_addr_o  (int_addr),
    .int_regfile_write_o (int_write),
    .fflags_o            (fflags),
    .fp_pending_o        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic d, input logic [4:0] rd,
                       input logic [31:0] data, input logic [7:0] st);
    in_valid  = v;
    in_dest   = d;
    in_rd     = rd;
    in_wdata  = data;
    in_status = st;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    busy = 1'b0;
    flush = 1'b0;
    csr_we = 1'b0;
    csr_wdata = 5'h0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_fpw", {31'b0, fp_write}, 32'h0);
    chk("rst_intw", {31'b0, int_write}, 32'h0);
    chk("rst_fflags", {27'b0, fflags}, 32'h0);
    chk("rst_pend", pending, 32'h0);

    // back-to-back FP results
    for (int i = 1; i <= 5; i++) begin
      drive(i <= 4, 1'b0, 5'(i), 32'h3F80_0000 + i, 8'h0);
      settle();
      chk("b2b_ready", {31'b0, in_ready}, 32'h1);
      if (i > 1) begin
        chk("b2b_fpw", {31'b0, fp_write}, 32'h1);
        chk("b2b_addr", {27'b0, fp_addr}, i - 1);
        chk("b2b_data", fp_wdata, 32'h3F80_0000 + i - 1);
        chk("b2b_pend", pending, 32'h1 << (i - 1));
      end else begin
        chk("b2b_fpw0", {31'b0, fp_write}, 32'h0);
        chk("b2b_pend0", pending, 32'h0);
      end
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    settle();
    chk("b2b_end_fpw", {31'b0, fp_write}, 32'h0);
    chk("b2b_end_pend", pending, 32'h0);
    tick();

    // INT stall
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 8'h0);
    tick();
    drive(1'b1, 1'b0, 5'd2, 32'h4000_0000, 8'h0);
    busy = 1'b1;
    settle();
    chk("st1_intw", {31'b0, int_write}, 32'h0);
    chk("st1_fpw", {31'b0, fp_write}, 32'h0);
    chk("st1_ready", {31'b0, in_ready}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    settle();
    chk("st2_ready", {31'b0, in_ready}, 32'h0);
    chk("st2_intw", {31'b0, int_write}, 32'h0);
    chk("st2_fpw", {31'b0, fp_write}, 32'h0);
    chk("st2_pend", pending, 32'h4);
    tick();
    settle();
    chk("st3_ready", {31'b0, in_ready}, 32'h0);
    chk("st3_intw", {31'b0, int_write}, 32'h0);
    tick();
    busy = 1'b0;
    settle();
    chk("st4_intw", {31'b0, int_write}, 32'h1);
    chk("st4_addr", {27'b0, int_addr}, 32'h5);
    chk("st4_data", int_wdata, 32'hDEAD_BEEF);
    chk("st4_fpw", {31'b0, fp_write}, 32'h0);
    chk("st4_ready", {31'b0, in_ready}, 32'h0);
    tick();
    settle();
    chk("st5_fpw", {31'b0, fp_write}, 32'h1);
    chk("st5_addr", {27'b0, fp_addr}, 32'h2);
    chk("st5_data", fp_wdata, 32'h4000_0000);
    chk("st5_intw", {31'b0, int_write}, 32'h0);
    chk("st5_ready", {31'b0, in_ready}, 32'h1);
    tick();
    settle();
    chk("st6_fpw", {31'b0, fp_write}, 32'h0);
    chk("st6_pend", pending, 32'h0);

    // flag accrual and CSR write
    drive(1'b1, 1'b0, 5'd7, 32'h0, 8'h10);
    tick();
    drive(1'b1, 1'b0, 5'd8, 32'h0, 8'h01);
    settle();
    chk("fl0", {27'b0, fflags}, 32'h00);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    settle();
    chk("fl1", {27'b0, fflags}, 32'h10);
    tick();
    drive(1'b1, 1'b0, 5'd9, 32'h0, 8'h04);
    settle();
    chk("fl2", {27'b0, fflags}, 32'h11);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    csr_we = 1'b1;
    csr_wdata = 5'h00;
    tick();
    csr_we = 1'b0;
    settle();
    chk("fl_csr", {27'b0, fflags}, 32'h04);

    // INT x0 destination
    drive(1'b1, 1'b1, 5'd0, 32'h1234_5678, 8'h02);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    settle();
    chk("x0_intw", {31'b0, int_write}, 32'h0);
    chk("x0_addr", {27'b0, int_addr}, 32'h0);
    chk("x0_data", int_wdata, 32'h0);
    chk("x0_fpw", {31'b0, fp_write}, 32'h0);
    tick();
    settle();
    chk("x0_flags", {27'b0, fflags}, 32'h06);
    chk("x0_ready", {31'b0, in_ready}, 32'h1);

    // flush with full buffer
    drive(1'b1, 1'b1, 5'd11, 32'h11, 8'h0);
    busy = 1'b1;
    tick();
    drive(1'b1, 1'b0, 5'd12, 32'h12, 8'h08);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    busy = 1'b0;
    flush = 1'b1;
    settle();
    chk("fls_ready", {31'b0, in_ready}, 32'h0);
    chk("fls_pend", pending, 32'h1000);
    chk("fls_intw", {31'b0, int_write}, 32'h1);
    chk("fls_addr", {27'b0, int_addr}, 32'd11);
    tick();
    flush = 1'b0;
    settle();
    chk("fls1_fpw", {31'b0, fp_write}, 32'h0);
    chk("fls1_intw", {31'b0, int_write}, 32'h0);
    chk("fls1_pend", pending, 32'h0);
    chk("fls1_ready", {31'b0, in_ready}, 32'h1);
    chk("fls1_flags", {27'b0, fflags}, 32'h06);
    drive(1'b1, 1'b0, 5'd13, 32'h13, 8'h01);
    flush = 1'b1;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    flush = 1'b0;
    settle();
    chk("fls2_fpw", {31'b0, fp_write}, 32'h0);
    chk("fls2_pend", pending, 32'h0);
    tick();

    // reset mid-run
    drive(1'b1, 1'b1, 5'd14, 32'h14, 8'h0);
    busy = 1'b1;
    csr_we = 1'b1;
    csr_wdata = 5'h1F;
    tick();
    csr_we = 1'b0;
    drive(1'b1, 1'b0, 5'd15, 32'h15, 8'h0);
    settle();
    chk("mr_flags", {27'b0, fflags}, 32'h1F);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 8'h0);
    busy = 1'b0;
    rst = 1'b1;
    settle();
    chk("mr_rst_intw", {31'b0, int_write}, 32'h0);
    chk("mr_rst_fpw", {31'b0, fp_write}, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("mr_flags0", {27'b0, fflags}, 32'h0);
    chk("mr_pend0", pending, 32'h0);
    chk("mr_ready", {31'b0, in_ready}, 32'h1);
    chk("mr_intw", {31'b0, int_write}, 32'h0);
    chk("mr_fpw", {31'b0, fp_write}, 32'h0);
    tick();
    settle();
    chk("mr2_intw", {31'b0, int_write}, 32'h0);
    chk("mr2_fpw", {31'b0, fp_write}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
